// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronises and debounces a WIDTH-bit input bus,
// latches qualified edges into a sticky write-1-to-clear capture register
// and raises a maskable level interrupt in edge or level mode.
module pio_in_edge_capture #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    MODE_RISE  = 2'd0,
    MODE_FALL  = 2'd1,
    MODE_ANY   = 2'd2,
    MODE_LEVEL = 2'd3
  } mode_e;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Count value at which a persistent difference is accepted into stable.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_q, s2_q;
  logic [WIDTH-1:0]            stable_q, stable_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            edgecap_q, edgecap_d;
  logic [WIDTH-1:0]            irqmask_q, irqmask_d;
  mode_e                       ctrl_q, ctrl_d;
  logic [31:0]                 readdata_q, readdata_d;

  logic [WIDTH-1:0]            update_c;
  logic [WIDTH-1:0]            cap_set_c;
  logic                        wr_c;

  // Only the low WIDTH bits (or two for CTRL) of a write carry meaning.
  logic                        unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_c = chipselect && !write_n;

  // Per-bit debounce: a difference must persist DEBOUNCE_CYCLES cycles at s2.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    update_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
          update_c[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Qualify accepted updates by the selected edge mode.
  always_comb begin
    cap_set_c = '0;
    unique case (ctrl_q)
      MODE_RISE:  cap_set_c = update_c & s2_q;
      MODE_FALL:  cap_set_c = update_c & ~s2_q;
      MODE_ANY:   cap_set_c = update_c;
      MODE_LEVEL: cap_set_c = '0;
      default:    cap_set_c = '0;
    endcase
  end

  // Register writes; a capture on the same edge overrides a W1C.
  always_comb begin
    ctrl_d    = ctrl_q;
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_c) begin
      unique case (address)
        ADDR_CTRL:    ctrl_d    = mode_e'(writedata[1:0]);
        ADDR_IRQMASK: irqmask_d = writedata[WIDTH-1:0];
        ADDR_EDGECAP: edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        default:      ;
      endcase
    end
    edgecap_d = edgecap_d | cap_set_c;
  end

  // Read mux from current register contents, independent of chipselect.
  always_comb begin
    readdata_d = '0;
    unique case (address)
      ADDR_DATA:    readdata_d = 32'(stable_q);
      ADDR_CTRL:    readdata_d = 32'(ctrl_q);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      ctrl_q     <= MODE_RISE;
      readdata_q <= '0;
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      ctrl_q     <= ctrl_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = (ctrl_q == MODE_LEVEL) ? |(stable_q & irqmask_q)
                                           : |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Bench for pio_in_edge_capture: directed scenarios plus randomized bus and
// input traffic, checked every cycle against a behavioural model.
module tb_pio_in_edge_capture;

  localparam int D = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [4:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  logic [31:0] in32;
  logic [31:0] rd32;
  logic        irq32;

  int checks;
  int failures;

  // Model state: value after the most recent clock edge.
  logic [4:0]  m_stable, m_edgecap, m_mask;
  logic [1:0]  m_ctrl;
  logic [31:0] m_rdata;
  logic [4:0]  hist [0:7];  // hist[j] = in_port sampled j edges ago

  pio_in_edge_capture #(.WIDTH(5), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  pio_in_edge_capture #(.WIDTH(32), .DEBOUNCE_CYCLES(1)) dut32 (
    .clk(clk), .reset_n(reset_n), .address(2'd0), .chipselect(1'b0),
    .write_n(1'b1), .writedata(32'd0), .in_port(in32),
    .readdata(rd32), .irq(irq32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_irq();
    if (m_ctrl == 2'd3) return |(m_stable & m_mask);
    return |(m_edgecap & m_mask);
  endfunction

  // One bus/input cycle: drive, predict the edge, clock, compare.
  task automatic cycle(input logic [1:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic [4:0] ip);
    logic [4:0]  upd, n_stable, cap, n_cap, n_mask;
    logic [1:0]  n_ctrl;
    logic [31:0] n_rd;
    logic        held;
    address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = ip;
    for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = ip;
    // A bit is accepted once its last D synchronised samples all differ.
    for (int i = 0; i < 5; i++) begin
      held = 1'b1;
      for (int j = 2; j <= D + 1; j++)
        if (hist[j][i] == m_stable[i]) held = 1'b0;
      upd[i] = held;
    end
    n_stable = m_stable ^ upd;
    case (m_ctrl)
      2'd0:    cap = upd & n_stable;
      2'd1:    cap = upd & ~n_stable;
      2'd2:    cap = upd;
      default: cap = 5'd0;
    endcase
    case (a)
      2'd0:    n_rd = {27'd0, m_stable};
      2'd1:    n_rd = {30'd0, m_ctrl};
      2'd2:    n_rd = {27'd0, m_mask};
      default: n_rd = {27'd0, m_edgecap};
    endcase
    n_cap = m_edgecap; n_ctrl = m_ctrl; n_mask = m_mask;
    if (cs && !wn) begin
      if (a == 2'd1) n_ctrl = wd[1:0];
      if (a == 2'd2) n_mask = wd[4:0];
      if (a == 2'd3) n_cap = n_cap & ~wd[4:0];
    end
    n_cap = n_cap | cap;
    @(posedge clk);
    m_stable = n_stable; m_edgecap = n_cap; m_ctrl = n_ctrl;
    m_mask = n_mask; m_rdata = n_rd;
    @(negedge clk);
    check("readdata", readdata, m_rdata);
    check("irq", {31'd0, irq}, {31'd0, model_irq()});
  endtask

  task automatic idle(input int n, input logic [4:0] ip);
    for (int k = 0; k < n; k++) cycle(2'd0, 1'b0, 1'b1, 32'd0, ip);
  endtask

  initial begin
    logic [4:0]  ip;
    logic [1:0]  a;
    logic        cs, wn;
    logic [31:0] wd;
    checks = 0; failures = 0;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; in_port = 5'd0; in32 = 32'd0;
    m_stable = '0; m_edgecap = '0; m_mask = '0; m_ctrl = '0; m_rdata = '0;
    for (int j = 0; j < 8; j++) hist[j] = '0;
    repeat (4) @(negedge clk);
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    // Idle reads of every register after reset.
    for (int r = 0; r < 4; r++) begin
      cycle(2'(r), 1'b1, 1'b1, 32'd0, 5'd0);
      check("idle_read", readdata, 32'd0);
    end

    // Rising capture with mask on bit 2.
    cycle(2'd1, 1'b1, 1'b0, 32'd0, 5'd0);
    cycle(2'd2, 1'b1, 1'b0, 32'd4, 5'd0);
    for (int j = 1; j <= 6; j++) begin
      cycle(2'd0, 1'b0, 1'b1, 32'd0, 5'b00100);
      if (j == 5) check("rise_irq_before", {31'd0, irq}, 32'd0);
      if (j == 6) check("rise_irq_after", {31'd0, irq}, 32'd1);
    end
    check("model_edgecap", {27'd0, m_edgecap}, 32'd4);
    cycle(2'd3, 1'b1, 1'b1, 32'd0, 5'b00100);
    check("rise_edgecap", readdata, 32'd4);
    cycle(2'd3, 1'b1, 1'b0, 32'd0, 5'b00100);
    check("w1c_zero_irq", {31'd0, irq}, 32'd1);
    cycle(2'd3, 1'b1, 1'b0, 32'd4, 5'b00100);
    check("w1c_preclear_read", readdata, 32'd4);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    cycle(2'd3, 1'b1, 1'b1, 32'd0, 5'b00100);
    check("w1c_cleared", readdata, 32'd0);

    // Glitch rejection and a just-long-enough pulse on bit 0.
    idle(8, 5'd0);
    cycle(2'd3, 1'b1, 1'b0, 32'h1f, 5'd0);
    idle(3, 5'd1);
    idle(8, 5'd0);
    cycle(2'd0, 1'b1, 1'b1, 32'd0, 5'd0);
    check("glitch_data", readdata, 32'd0);
    cycle(2'd3, 1'b1, 1'b1, 32'd0, 5'd0);
    check("glitch_cap", readdata, 32'd0);
    idle(4, 5'd1);
    idle(8, 5'd0);
    cycle(2'd3, 1'b1, 1'b1, 32'd0, 5'd0);
    check("pulse_cap", readdata, 32'd1);

    // W1C of bit 1 on the same edge as its capture.
    cycle(2'd3, 1'b1, 1'b0, 32'h1f, 5'd0);
    idle(5, 5'b00010);
    cycle(2'd3, 1'b1, 1'b0, 32'd2, 5'b00010);
    cycle(2'd3, 1'b1, 1'b1, 32'd0, 5'b00010);
    check("collision_cap", readdata, 32'd2);

    // Level mode follows stable & mask; edgecap untouched.
    cycle(2'd1, 1'b1, 1'b0, 32'd3, 5'b00010);
    cycle(2'd2, 1'b1, 1'b0, 32'd1, 5'b00010);
    check("level_irq_low", {31'd0, irq}, 32'd0);
    idle(6, 5'b00011);
    check("level_irq_high", {31'd0, irq}, 32'd1);
    cycle(2'd3, 1'b1, 1'b1, 32'd0, 5'b00011);
    check("level_edgecap", readdata, 32'd2);

    // Wide instance with no debounce.
    in32 = 32'hffff_ffff;
    idle(2, 5'b00011);
    idle(1, 5'b00011);
    check("wide_data_early", rd32, 32'd0);
    idle(1, 5'b00011);
    check("wide_data", rd32, 32'hffff_ffff);
    check("wide_irq", {31'd0, irq32}, 32'd0);

    // Randomized traffic.
    ip = 5'b00011;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) ip = ip ^ 5'($urandom);
      a  = 2'($urandom);
      cs = 1'($urandom);
      wn = ($urandom_range(0, 7) != 0);
      wd = $urandom;
      cycle(a, cs, wn, wd, ip);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_capture.md
# pio_in_edge_capture

Parametrised Avalon-MM input PIO that succeeds the fixed-width 5-bit button/switch port. It synchronises and debounces a `WIDTH`-bit external input bus and latches edges in a sticky, write-1-to-clear capture register. It raises a maskable level interrupt in edge or level mode. The block sits on the system interconnect as a memory-mapped slave next to the other PIO peripherals.

## Interface

**Parameters**
- `WIDTH`, default 5: number of input bits, from 1 to 32.
- `DEBOUNCE_CYCLES`, default 1: consecutive stable cycles required before an input change is accepted. The minimum is 1; a value of 1 means no debounce.
- `CNT_W`, default `clog2(DEBOUNCE_CYCLES+1)`: width of the debounce counter.

**Ports**
- `clk` (in, 1): clock.
- `reset_n` (in, 1): reset, asynchronous, active-low.
- `address` (in, 2): register select.
- `chipselect` (in, 1): slave select.
- `write_n` (in, 1): active-low write strobe.
- `writedata` (in, 32): write data.
- `in_port` (in, `WIDTH`): asynchronous external inputs.
- `readdata` (out, 32): registered read data, zero-extended.
- `irq` (out, 1): active-high level interrupt.

## Operation

**Register map.** A write occurs when `chipselect && !write_n`.
- Address 0, DATA (RO): debounced input value `stable[WIDTH-1:0]`. Writes are ignored.
- Address 1, CTRL (RW): bits [1:0] select the mode.
  - 0: rising edge.
  - 1: falling edge.
  - 2: any edge.
  - 3: level.
  - Bits [31:2] read as 0.
- Address 2, IRQMASK (RW): bits [WIDTH-1:0].
- Address 3, EDGECAP (R/W1C): sticky capture bits. Writing 1 to a bit clears that bit; writing 0 has no effect.

**Input path (per bit)**
- Two-flop synchroniser: `s1 <= in_port`, `s2 <= s1`.
- Debounce with a per-bit counter `cnt[CNT_W-1:0]`:
  - If `s2 == stable`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`. This is the "update" event.
  - Else: `cnt <= cnt + 1`.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` resets the counter and never reaches `stable`.

**Edge capture**
- On an update, set `edgecap[i]` on the same clock edge if the mode matches:
  - Rising mode: `s2 == 1`.
  - Falling mode: `s2 == 0`.
  - Any-edge mode: always.
  - Level mode: never.
- EDGECAP bits stay set until cleared by W1C.
- Simultaneous W1C and a new capture on the same bit in the same cycle: the capture wins and the bit stays 1.
- Writing CTRL does not clear EDGECAP. Captures already latched remain.

**Interrupt**
- Edge modes: `irq = |(edgecap & irqmask)`.
- Level mode: `irq = |(stable & irqmask)`.
- `irq` is combinational from registers, with no path from `in_port` that bypasses the flops.

**Read**
- `readdata <= zero-extended mux(address)` on every clock, independent of `chipselect`. Unused bits are 0.

## Timing

**Reset values.** All flops clear asynchronously on `reset_n = 0`:
- `s1`, `s2`, `stable`, `cnt`, `edgecap`, `irqmask` = 0.
- CTRL = 0 (rising mode).
- `readdata` = 0.
- Consequence: `irq` = 0 during and after reset until a capture occurs.
- An input held high through reset is accepted as a rising edge `DEBOUNCE_CYCLES+1` edges after release. This is intentional, and software clears it at init.
- Reset asserted mid-debounce discards the count.

**Latency.** Take `in_port` stable before clock edge k with D = `DEBOUNCE_CYCLES`:
- `s2` changes at edge k+1.
- `stable` and `edgecap` update at edge k+1+D, and `irq` rises right after that edge.
- DATA is visible on `readdata` at edge k+2+D.

**Bus timing**
- Read latency is 1 cycle: `readdata` is valid the edge after `address` is presented.
- Register writes take effect at the write edge.
- A read of EDGECAP in the same cycle as a W1C returns the pre-clear value.

**Counter bounds.** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.

## Test plan

- **Reset and idle read.** Hold `in_port=0` through reset, release, then read addresses 0–3 → all 0 and `irq=0`.
- **Rising capture and interrupt.** With WIDTH=5, D=4, CTRL=0, IRQMASK=5'b00100, step `in_port` from 0 to 5'b00100:
  - `edgecap` = 5'b00100 and `irq` = 1 exactly 5 edges after the input is sampled.
  - W1C 5'b00100 → `irq` = 0 the next cycle.
  - W1C 0 → no change.
- **Glitch rejection.** With D=4, pulse bit 0 high for 3 cycles → DATA stays 0 and no capture. A 4-cycle-stable pulse is accepted.
- **Mode coverage.**
  - Falling mode with a 1→0 transition captures; a 0→1 transition does not.
  - Any-edge mode captures both.
  - Level mode: `irq` follows `stable & mask` and `edgecap` stays 0.
- **Clear/capture collision.** Arrange a W1C of bit 1 on the same edge as a new bit-1 update → bit 1 reads 1 afterwards.
- **Width scaling.** With WIDTH=32 and D=1, toggle all bits → DATA = 32'hFFFFFFFF two edges after sampling, and `readdata` upper bits stay 0 when WIDTH=5.
